// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: one-hot mode encoding and mode width.
package stopwatch_pkg;

    localparam int unsigned MODE_W = 4;

    // One-hot mode states, also decoded by the display and LED blocks
    localparam logic [MODE_W-1:0] IDLE  = 4'b0001;
    localparam logic [MODE_W-1:0] RUN   = 4'b0010;
    localparam logic [MODE_W-1:0] LAP   = 4'b0100;
    localparam logic [MODE_W-1:0] PAUSE = 4'b1000;

endpackage

// File: rtl/stopwatch_key_ctrl_if.sv
// Key-in / control-out bundle between the key filters, the mode controller and the counter.
interface stopwatch_key_ctrl_if;
    import stopwatch_pkg::*;

    logic              key_ss;
    logic              key_lap;
    logic              run;
    logic              lap_hold;
    logic              cmd_lap;
    logic              cmd_clear;
    logic [MODE_W-1:0] mode;

    // Master drives the debounced keys and observes the controls
    modport master (
        output key_ss, key_lap,
        input  run, lap_hold, cmd_lap, cmd_clear, mode
    );

    // Slave is the mode controller
    modport slave (
        input  key_ss, key_lap,
        output run, lap_hold, cmd_lap, cmd_clear, mode
    );

endinterface

// File: rtl/key_event_det.sv
// Per-key press-edge detector with an optional long-press detector.
module key_event_det #(
    parameter int unsigned LONG_EN  = 0,
    parameter int unsigned LONG_CNT = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    output logic press,
    output logic long_press
);

    localparam int unsigned CNT_W = $clog2(LONG_CNT + 1);

    logic prev_q;

    // Previous sample resets to 1 so a key held through reset gives no press
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= key;
        end
    end

    assign press = key & ~prev_q;

    if (LONG_EN != 0) begin : gen_long
        logic [CNT_W-1:0] lcnt_q;
        logic [CNT_W-1:0] lcnt_d;

        // Count sampled-high cycles, clear on release, saturate at the threshold
        always_comb begin
            lcnt_d = lcnt_q;
            if (!key) begin
                lcnt_d = '0;
            end else if (lcnt_q < CNT_W'(LONG_CNT)) begin
                lcnt_d = lcnt_q + 1'b1;
            end
        end

        // Long-press counter register
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                lcnt_q <= '0;
            end else begin
                lcnt_q <= lcnt_d;
            end
        end

        // Fires only on the LONG_CNT-1 -> LONG_CNT step, once per hold
        assign long_press = key & (lcnt_q == CNT_W'(LONG_CNT - 1));
    end else begin : gen_no_long
        // Keeps the width parameter referenced; no logic remains
        logic [CNT_W-1:0] unused_cnt;
        assign unused_cnt = '0;
        assign long_press = 1'b0;
    end

endmodule

// File: rtl/stopwatch_key_ctrl.sv
// Stopwatch mode controller: press/long-press events drive a one-hot four-state machine.
module stopwatch_key_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50000000,
    parameter int unsigned LONG_MS  = 1000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    stopwatch_key_ctrl_if.slave  bus
);

    localparam int unsigned LONG_CNT = CLK_FREQ / 1000 * LONG_MS;

    logic              ss_press;
    logic              ss_long_unused;
    logic              lap_press;
    logic              lap_long;

    logic [MODE_W-1:0] state_q;
    logic [MODE_W-1:0] state_d;
    logic              cmd_lap_d;
    logic              cmd_clear_d;
    logic              run_q;
    logic              lap_hold_q;
    logic              cmd_lap_q;
    logic              cmd_clear_q;

    key_event_det #(
        .LONG_EN  (0),
        .LONG_CNT (LONG_CNT)
    ) u_ss_det (
        .clk        (clk),
        .rst_n      (rst_n),
        .key        (bus.key_ss),
        .press      (ss_press),
        .long_press (ss_long_unused)
    );

    key_event_det #(
        .LONG_EN  (1),
        .LONG_CNT (LONG_CNT)
    ) u_lap_det (
        .clk        (clk),
        .rst_n      (rst_n),
        .key        (bus.key_lap),
        .press      (lap_press),
        .long_press (lap_long)
    );

    // Next state and command pulses; ss_press wins and drops any lap event
    always_comb begin
        state_d     = state_q;
        cmd_lap_d   = 1'b0;
        cmd_clear_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ss_press) state_d = RUN;
            end
            RUN: begin
                if (ss_press) begin
                    state_d = PAUSE;
                end else if (lap_press) begin
                    state_d   = LAP;
                    cmd_lap_d = 1'b1;
                end
            end
            LAP: begin
                if (ss_press) begin
                    state_d = PAUSE;
                end else if (lap_press) begin
                    state_d = RUN;
                end
            end
            PAUSE: begin
                if (ss_press) begin
                    state_d = RUN;
                end else if (lap_long) begin
                    state_d     = IDLE;
                    cmd_clear_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers, outputs decoded from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            run_q       <= 1'b0;
            lap_hold_q  <= 1'b0;
            cmd_lap_q   <= 1'b0;
            cmd_clear_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_q       <= (state_d == RUN) || (state_d == LAP);
            lap_hold_q  <= (state_d == LAP);
            cmd_lap_q   <= cmd_lap_d;
            cmd_clear_q <= cmd_clear_d;
        end
    end

    assign bus.run       = run_q;
    assign bus.lap_hold  = lap_hold_q;
    assign bus.cmd_lap   = cmd_lap_q;
    assign bus.cmd_clear = cmd_clear_q;
    assign bus.mode      = state_q;

endmodule

// File: doc/stopwatch_key_ctrl.md
# stopwatch_key_ctrl

Mode controller for the stopwatch. It turns two debounced push-button levels into the run, lap-freeze and clear controls for the time counter and display.

- Inputs come from the key debounce filters: 1 = pressed, clean and synchronous to `clk`.
- It detects press edges and a long press, and sequences a four-state mode machine.
- It emits a level `run` enable, a level display-freeze, and single-cycle command pulses to the timebase/counter block.

## Interface
Parameters
- `CLK_FREQ`, 50000000: clock frequency in Hz.
- `LONG_MS`, 1000: long-press threshold in ms.
- `LONG_CNT` (localparam) = CLK_FREQ/1000*LONG_MS: number of consecutive sampled-high cycles that defines a long press.
- `CNT_W` (localparam) = $clog2(LONG_CNT+1).

Ports
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `key_ss` in 1: debounced start/stop key, 1 = pressed.
- `key_lap` in 1: debounced lap/clear key, 1 = pressed.
- `run` out 1: time counter enable.
- `lap_hold` out 1: display freeze; the display shows the captured lap value.
- `cmd_lap` out 1: one-cycle pulse, capture the current time into the lap register.
- `cmd_clear` out 1: one-cycle pulse, zero the time counter and the lap register.
- `mode` out 4: current state, one-hot.

## Operation
- **Edge detect.** Each key has a previous-sample register, and both of these registers reset to 1.
  - A key held down through reset release therefore generates no press.
  - `ss_press` = key_ss & ~ss_d; `lap_press` = key_lap & ~lap_d.
- **Long press.** `lcnt` counts the cycles in which key_lap is sampled 1.
  - It clears to 0 whenever key_lap = 0.
  - It saturates at LONG_CNT.
  - `lap_long` is 1 only in the cycle where lcnt transitions LONG_CNT-1 -> LONG_CNT. It fires exactly once per hold and re-arms only after release.
- **States.** IDLE = 4'b0001, RUN = 4'b0010, LAP = 4'b0100, PAUSE = 4'b1000.
  - IDLE: ss_press -> RUN. lap_press and lap_long are ignored.
  - RUN: ss_press -> PAUSE. lap_press -> LAP and pulse cmd_lap.
  - LAP: lap_press -> RUN, freeze released. ss_press -> PAUSE, freeze released.
  - PAUSE: ss_press -> RUN. lap_long -> IDLE and pulse cmd_clear. lap_press is ignored.
  - Illegal or non-one-hot state -> IDLE, with no pulse.
- **Outputs.** All registered, decoded from the next state.
  - run = 1 in RUN and in LAP.
  - lap_hold = 1 only in LAP.
  - mode mirrors the state register.
- **Simultaneous events** in the same cycle:
  - ss_press has priority over lap_press and lap_long; the lap event is dropped, not queued.
  - A lap_press coinciding with lap_long in PAUSE cannot occur when LONG_CNT >= 2. LONG_CNT < 2 is not supported.
- **Reset values.** run = 0, lap_hold = 0, cmd_lap = 0, cmd_clear = 0, mode = IDLE (4'b0001), lcnt = 0.
- **Reset mid-operation.** Any pulse in flight is killed immediately and outputs return to their reset values asynchronously. No clear pulse is issued; the downstream counter is reset by the same rst_n.

## Timing
- **Press latency.** Key sampled 0 at edge k-1 and 1 at edge k -> the new state, run/lap_hold and any command pulse appear after edge k. This is a 1-cycle response from the first sampled-high edge.
- **Long-press latency.** cmd_clear asserts after the edge at which key_lap has been sampled 1 for LONG_CNT consecutive edges.
- **Pulse width.** cmd_lap and cmd_clear are exactly 1 cycle high and never both high in the same cycle.
- **Hold behaviour.** A held key produces a single press event; there is no auto-repeat.

## Structure
- **Shared package `stopwatch_pkg`** holds:
  - the one-hot state constants IDLE/RUN/LAP/PAUSE;
  - the mode width (4), which the display and LED blocks also use.
- **Sub-module `key_event_det`** is one instance per key and contains the previous-sample register, the press-edge output and the optional long-press counter.
  - Parameter LONG_EN: 0 for key_ss, 1 for key_lap.
  - When LONG_EN = 0, the counter logic must synthesize away.
- The top contains only the state register, the next-state logic and the output registers.

## Test plan
Simulation uses CLK_FREQ = 1000 and LONG_MS = 5, giving LONG_CNT = 5.
- **Reset with keys held.** Release rst_n with key_ss = key_lap = 1 held for 10 cycles, then release both -> mode stays 4'b0001, with no pulses and run = 0.
- **Start/lap/stop.** key_ss pulse -> run = 1 one cycle after the sampled edge. key_lap 2-cycle pulse -> cmd_lap high for exactly 1 cycle, lap_hold = 1, mode = 4'b0100. Second key_lap pulse -> lap_hold = 0, mode = 4'b0010. key_ss pulse -> run = 0, mode = 4'b1000.
- **Long press in PAUSE.** Hold key_lap 4 cycles -> no clear. Hold key_lap 20 cycles -> a single cmd_clear pulse on the 5th sampled-high edge and mode = 4'b0001. Releasing and holding again in IDLE -> no pulse.
- **Simultaneous press in RUN.** key_ss and key_lap rise in the same cycle -> mode = PAUSE, cmd_lap = 0, lap_hold = 0.
- **Reset mid-operation.** Assert rst_n = 0 asynchronously in the cycle cmd_lap is high -> cmd_lap drops immediately, all outputs at their reset values, mode = 4'b0001.
- **State recovery.** Force the state register to 4'b0110 -> next cycle mode = 4'b0001, with no pulse.
